// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO result registers.
//
// One operation is accepted per start pulse while idle. Arithmetic ops hold
// busy for a fixed latency (MUL_CYCLES or DIV_CYCLES) and commit HI/LO on
// the last busy edge, followed by a one-cycle done pulse. MTHI/MTLO write
// HI/LO directly at the start edge without going busy.
//
// Ports:
//   clk    - clock, rising-edge active
//   reset  - asynchronous active-high reset (aborts any operation)
//   start  - request, sampled on a rising edge while busy = 0
//   op     - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//            100 MTHI, 101 MTLO, 110 MADD, 111 MSUB
//   a, b   - operands (WIDTH bits)
//   busy   - operation in flight
//   done   - one-cycle pulse after HI/LO are committed
//   hi, lo - HI and LO result registers
module md_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MUL_LAT = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_LAT = CW'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]         state;
  logic [CW-1:0]      cnt;
  logic [2:0]         op_p0;
  logic [WIDTH-1:0]   a_p0;
  logic [WIDTH-1:0]   b_p0;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] quot_rem;
  logic [2*WIDTH-1:0] result;
  logic               accept;
  logic               is_move;
  logic               is_div;

  // Full 2*WIDTH product. The low 2*WIDTH bits of the product of the
  // sign-extended operands equal the signed product, so one multiplier
  // serves both signed and unsigned forms.
  function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic             sgn);
    logic [2*WIDTH-1:0] xe;
    logic [2*WIDTH-1:0] ye;
    xe = sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
    ye = sgn ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
    return xe * ye;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes, then
  // the quotient takes the XOR of the signs and the remainder the dividend's
  // sign. Most-negative / -1 needs no special case: the magnitude quotient
  // 2^(WIDTH-1) reads back as the most negative value with remainder 0.
  function automatic logic [2*WIDTH-1:0] div_full(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic             sgn);
    logic             neg_x;
    logic             neg_y;
    logic [WIDTH-1:0] mx;
    logic [WIDTH-1:0] my;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    if (y == '0) begin
      return {x, {WIDTH{1'b1}}};
    end
    neg_x = sgn & x[WIDTH-1];
    neg_y = sgn & y[WIDTH-1];
    mx    = neg_x ? -x : x;
    my    = neg_y ? -y : y;
    q     = mx / my;
    r     = mx % my;
    if (neg_x ^ neg_y) q = -q;
    if (neg_x)         r = -r;
    return {r, q};
  endfunction

  assign is_move = (op == OP_MTHI) || (op == OP_MTLO);
  assign is_div  = (op == OP_DIV)  || (op == OP_DIVU);
  assign accept  = (state == IDLE) && start;
  assign busy    = (state == RUN);

  // Stage p0: operands captured at the accepting edge; a/b may change afterwards.
  always_ff @(posedge clk) begin
    if (accept && !is_move) begin
      op_p0 <= op;
      a_p0  <= a;
      b_p0  <= b;
    end
  end

  // Result formed from the latched operands and the HI/LO value at commit time.
  always_comb begin
    prod     = mul_full(a_p0, b_p0, op_p0 != OP_MULTU);
    quot_rem = div_full(a_p0, b_p0, op_p0 == OP_DIV);
    result   = {hi, lo};
    case (op_p0)
      OP_MULT, OP_MULTU: result = prod;
      OP_MADD:           result = {hi, lo} + prod;
      OP_MSUB:           result = {hi, lo} - prod;
      OP_DIV, OP_DIVU:   result = quot_rem;
      default:           result = {hi, lo};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end else begin
              state <= RUN;
              cnt   <= is_div ? DIV_LAT : MUL_LAT;
            end
          end
        end
        default: begin
          cnt <= cnt - CW'(1);
          // Commit on the last busy edge; done is seen in the following cycle.
          if (cnt == CW'(1)) begin
            hi    <= result[2*WIDTH-1:WIDTH];
            lo    <= result[WIDTH-1:0];
            state <= IDLE;
            done  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit. Two instances run the same scenarios: one with the
// default parameters (32-bit, 5/10 cycles) and one with WIDTH=16,
// MUL_CYCLES=1, DIV_CYCLES=3. Expected HI/LO come from a behavioural model
// and are queued when an operation is started, then popped on done.
module tb_md_unit;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  logic        clk = 1'b0;
  logic        reset0 = 1'b1, reset1 = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [2:0]  op0 = '0, op1 = '0;
  logic [31:0] a0 = '0, b0 = '0;
  logic [15:0] a1 = '0, b1 = '0;
  logic        busy0, done0, busy1, done1;
  logic [31:0] hi0, lo0;
  logic [15:0] hi1, lo1;

  int checks = 0;
  int errors = 0;

  logic [63:0]  mhi [2];
  logic [63:0]  mlo [2];
  logic [127:0] sbq [$];

  always #5 clk = ~clk;

  md_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) u0 (
    .clk(clk), .reset(reset0), .start(start0), .op(op0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .hi(hi0), .lo(lo0));

  md_unit #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) u1 (
    .clk(clk), .reset(reset1), .start(start1), .op(op1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .hi(hi1), .lo(lo1));

  function automatic int wid(input int sel);  return (sel != 0) ? 16 : 32; endfunction
  function automatic int mulc(input int sel); return (sel != 0) ? 1 : 5;   endfunction
  function automatic int divc(input int sel); return (sel != 0) ? 3 : 10;  endfunction
  function automatic logic [63:0] mask(input int sel);
    return (64'd1 << wid(sel)) - 64'd1;
  endfunction
  function automatic logic [63:0] get_hi(input int sel);
    return (sel != 0) ? {48'd0, hi1} : {32'd0, hi0};
  endfunction
  function automatic logic [63:0] get_lo(input int sel);
    return (sel != 0) ? {48'd0, lo1} : {32'd0, lo0};
  endfunction
  function automatic logic get_busy(input int sel); return (sel != 0) ? busy1 : busy0; endfunction
  function automatic logic get_done(input int sel); return (sel != 0) ? done1 : done0; endfunction

  task automatic drv(input int sel, input logic s, input logic [2:0] o,
                     input logic [63:0] av, input logic [63:0] bv);
    if (sel != 0) begin
      start1 = s; op1 = o; a1 = av[15:0]; b1 = bv[15:0];
    end else begin
      start0 = s; op0 = o; a0 = av[31:0]; b0 = bv[31:0];
    end
  endtask

  task automatic set_reset(input int sel, input logic v);
    if (sel != 0) reset1 = v;
    else          reset0 = v;
  endtask

  // Behavioural model: returns {hi, lo}, each zero-extended to 64 bits.
  function automatic logic [127:0] model(input int w, input logic [2:0] o,
                                         input logic [63:0] av, input logic [63:0] bv,
                                         input logic [63:0] h, input logic [63:0] l);
    logic [63:0] m, m2, acc, res, rh, rl;
    longint sa, sb, q, r;
    m   = (64'd1 << w) - 64'd1;
    m2  = ~64'd0 >> (64 - 2 * w);
    sa  = av[w-1] ? longint'(av) - longint'(64'd1 << w) : longint'(av);
    sb  = bv[w-1] ? longint'(bv) - longint'(64'd1 << w) : longint'(bv);
    acc = ((h << w) | l) & m2;
    res = acc;
    rh  = h;
    rl  = l;
    case (o)
      OP_MULT:  res = 64'(sa * sb) & m2;
      OP_MULTU: res = (av * bv) & m2;
      OP_MADD:  res = (acc + 64'(sa * sb)) & m2;
      OP_MSUB:  res = (acc - 64'(sa * sb)) & m2;
      default:  res = acc;
    endcase
    rh = (res >> w) & m;
    rl = res & m;
    if (o == OP_DIV || o == OP_DIVU) begin
      if (bv == 64'd0) begin
        rh = av; rl = m;
      end else if (o == OP_DIV) begin
        q = sa / sb; r = sa % sb;
        rl = 64'(q) & m; rh = 64'(r) & m;
      end else begin
        rl = av / bv; rh = av % bv;
      end
    end
    return {rh, rl};
  endfunction

  // Starts one arithmetic op and follows it to done, checking busy, HI/LO
  // hold, latency and the committed result. With inject set, an MTLO start
  // is issued in the first busy cycle and must be ignored.
  task automatic run_op(input int sel, input logic [2:0] o, input logic [63:0] av_in,
                        input logic [63:0] bv_in, input bit inject);
    logic [63:0]  av, bv, hh, hl;
    logic [127:0] e;
    int           lat;
    bit           seen;
    av   = av_in & mask(sel);
    bv   = bv_in & mask(sel);
    seen = 0;
    lat  = (o == OP_DIV || o == OP_DIVU) ? divc(sel) : mulc(sel);
    sbq.push_back(model(wid(sel), o, av, bv, mhi[sel], mlo[sel]));
    drv(sel, 1'b1, o, av, bv);
    @(posedge clk); #1;
    drv(sel, 1'b0, o, {$urandom, $urandom}, {$urandom, $urandom});
    checks++;
    if (get_busy(sel) !== 1'b1) begin
      errors++; $display("FAIL busy_after_start sel=%0d op=%0d got %b want 1", sel, o, get_busy(sel));
    end
    hh = get_hi(sel);
    hl = get_lo(sel);
    for (int c = 1; c <= lat + 2 && !seen; c++) begin
      if (inject && c == 1) drv(sel, 1'b1, OP_MTLO, 64'hDEAD, 64'd0);
      @(posedge clk); #1;
      if (inject && c == 1) drv(sel, 1'b0, OP_MTLO, 64'd0, 64'd0);
      if (get_done(sel) === 1'b1) begin
        seen = 1;
        e = sbq.pop_front();
        checks++;
        if (c != lat) begin
          errors++; $display("FAIL latency sel=%0d op=%0d got %0d want %0d", sel, o, c, lat);
        end
        checks++;
        if (get_hi(sel) !== e[127:64]) begin
          errors++; $display("FAIL hi sel=%0d op=%0d got %h want %h", sel, o, get_hi(sel), e[127:64]);
        end
        checks++;
        if (get_lo(sel) !== e[63:0]) begin
          errors++; $display("FAIL lo sel=%0d op=%0d got %h want %h", sel, o, get_lo(sel), e[63:0]);
        end
        checks++;
        if (get_busy(sel) !== 1'b0) begin
          errors++; $display("FAIL busy_at_done sel=%0d got %b want 0", sel, get_busy(sel));
        end
        mhi[sel] = e[127:64];
        mlo[sel] = e[63:0];
      end else begin
        checks++;
        if (get_busy(sel) !== 1'b1 || get_hi(sel) !== hh || get_lo(sel) !== hl) begin
          errors++;
          $display("FAIL hold sel=%0d cyc=%0d got busy=%b hi=%h lo=%h want busy=1 hi=%h lo=%h",
                   sel, c, get_busy(sel), get_hi(sel), get_lo(sel), hh, hl);
        end
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout sel=%0d op=%0d got no done want done after %0d", sel, o, lat);
      e = sbq.pop_front();
    end
  endtask

  task automatic test_reset(input int sel);
    set_reset(sel, 1'b1);
    #1;
    checks++;
    if (get_busy(sel) !== 1'b0 || get_done(sel) !== 1'b0 || get_hi(sel) !== 64'd0 || get_lo(sel) !== 64'd0) begin
      errors++;
      $display("FAIL reset_state sel=%0d got busy=%b done=%b hi=%h lo=%h want all 0",
               sel, get_busy(sel), get_done(sel), get_hi(sel), get_lo(sel));
    end
    @(posedge clk); #1;
    set_reset(sel, 1'b0);
    mhi[sel] = 64'd0;
    mlo[sel] = 64'd0;
    @(posedge clk); #1;
    checks++;
    if (get_busy(sel) !== 1'b0 || get_done(sel) !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset sel=%0d got busy=%b done=%b want 0 0", sel, get_busy(sel), get_done(sel));
    end
  endtask

  task automatic test_mult(input int sel);
    logic [63:0] m;
    m = mask(sel);
    run_op(sel, OP_MULT, -64'd2, 64'd3, 0);
    checks++;
    if (get_hi(sel) !== m || get_lo(sel) !== (m - 64'd5)) begin
      errors++; $display("FAIL mult_const sel=%0d got %h_%h want %h_%h", sel, get_hi(sel), get_lo(sel), m, m - 64'd5);
    end
  endtask

  task automatic test_mac(input int sel);
    logic [63:0] m;
    m = mask(sel);
    run_op(sel, OP_MULTU, m, 64'd2, 0);
    run_op(sel, OP_MADD, 64'd1, 64'd1, 0);
    checks++;
    if (get_hi(sel) !== 64'd1 || get_lo(sel) !== m) begin
      errors++; $display("FAIL madd_const sel=%0d got %h_%h want %h_%h", sel, get_hi(sel), get_lo(sel), 64'd1, m);
    end
    run_op(sel, OP_MSUB, 64'd2, 64'd1, 0);
    checks++;
    if (get_lo(sel) !== (m - 64'd2)) begin
      errors++; $display("FAIL msub_const sel=%0d got %h want %h", sel, get_lo(sel), m - 64'd2);
    end
  endtask

  task automatic test_div(input int sel);
    run_op(sel, OP_DIV, -64'd7, 64'd2, 0);
    checks++;
    if (get_lo(sel) !== (mask(sel) - 64'd2) || get_hi(sel) !== mask(sel)) begin
      errors++; $display("FAIL div_const sel=%0d got hi=%h lo=%h want hi=%h lo=%h",
                         sel, get_hi(sel), get_lo(sel), mask(sel), mask(sel) - 64'd2);
    end
    run_op(sel, OP_DIVU, 64'd7, 64'd2, 0);
    checks++;
    if (get_lo(sel) !== 64'd3 || get_hi(sel) !== 64'd1) begin
      errors++; $display("FAIL divu_const sel=%0d got hi=%h lo=%h want hi=1 lo=3", sel, get_hi(sel), get_lo(sel));
    end
  endtask

  task automatic test_div_edge(input int sel);
    logic [63:0] mn;
    mn = 64'd1 << (wid(sel) - 1);
    run_op(sel, OP_DIVU, 64'd5, 64'd0, 0);
    checks++;
    if (get_lo(sel) !== mask(sel) || get_hi(sel) !== 64'd5) begin
      errors++; $display("FAIL div_by_zero sel=%0d got hi=%h lo=%h want hi=5 lo=%h", sel, get_hi(sel), get_lo(sel), mask(sel));
    end
    run_op(sel, OP_DIV, mn, mask(sel), 0);
    checks++;
    if (get_lo(sel) !== mn || get_hi(sel) !== 64'd0) begin
      errors++; $display("FAIL div_overflow sel=%0d got hi=%h lo=%h want hi=0 lo=%h", sel, get_hi(sel), get_lo(sel), mn);
    end
  endtask

  task automatic test_moves(input int sel);
    drv(sel, 1'b1, OP_MTHI, 64'h1234, 64'd0);
    @(posedge clk); #1;
    checks++;
    if (get_busy(sel) !== 1'b0 || get_hi(sel) !== 64'h1234) begin
      errors++; $display("FAIL mthi sel=%0d got busy=%b hi=%h want busy=0 hi=1234", sel, get_busy(sel), get_hi(sel));
    end
    drv(sel, 1'b1, OP_MTLO, 64'h5678, 64'd0);
    @(posedge clk); #1;
    drv(sel, 1'b0, OP_MTLO, 64'd0, 64'd0);
    checks++;
    if (get_busy(sel) !== 1'b0 || get_done(sel) !== 1'b0 || get_lo(sel) !== 64'h5678 || get_hi(sel) !== 64'h1234) begin
      errors++; $display("FAIL mtlo sel=%0d got busy=%b done=%b hi=%h lo=%h want 0 0 1234 5678",
                         sel, get_busy(sel), get_done(sel), get_hi(sel), get_lo(sel));
    end
    mhi[sel] = 64'h1234;
    mlo[sel] = 64'h5678;
    @(posedge clk); #1;
    checks++;
    if (get_busy(sel) !== 1'b0 || get_done(sel) !== 1'b0) begin
      errors++; $display("FAIL move_no_busy sel=%0d got busy=%b done=%b want 0 0", sel, get_busy(sel), get_done(sel));
    end
  endtask

  task automatic test_ignore(input int sel);
    run_op(sel, OP_DIV, 64'd100, 64'd7, 1);
    checks++;
    if (get_lo(sel) !== 64'd14 || get_hi(sel) !== 64'd2) begin
      errors++; $display("FAIL ignore_start sel=%0d got hi=%h lo=%h want hi=2 lo=e", sel, get_hi(sel), get_lo(sel));
    end
  endtask

  task automatic test_back_to_back(input int sel);
    run_op(sel, OP_MULT, 64'd6, 64'd7, 0);
    run_op(sel, OP_DIVU, 64'd50, 64'd6, 0);
    run_op(sel, OP_MADD, -64'd1, 64'd9, 0);
    for (int i = 0; i < 6; i++) begin
      logic [2:0] o;
      logic [63:0] bv;
      case ($urandom_range(0, 5))
        0: o = OP_MULT;  1: o = OP_MULTU; 2: o = OP_DIV;
        3: o = OP_DIVU;  4: o = OP_MADD;  default: o = OP_MSUB;
      endcase
      bv = (i == 3) ? 64'd0 : {$urandom, $urandom};
      run_op(sel, o, {$urandom, $urandom}, bv, 0);
    end
  endtask

  task automatic test_abort(input int sel);
    int lat, k;
    lat = mulc(sel);
    k   = (lat >= 3) ? 2 : lat - 1;
    drv(sel, 1'b1, OP_MULT, 64'd123, 64'd45);
    @(posedge clk); #1;
    drv(sel, 1'b0, OP_MULT, 64'd0, 64'd0);
    repeat (k) begin
      @(posedge clk); #1;
    end
    set_reset(sel, 1'b1);
    #1;
    checks++;
    if (get_busy(sel) !== 1'b0 || get_hi(sel) !== 64'd0 || get_lo(sel) !== 64'd0) begin
      errors++; $display("FAIL abort sel=%0d got busy=%b hi=%h lo=%h want 0 0 0", sel, get_busy(sel), get_hi(sel), get_lo(sel));
    end
    mhi[sel] = 64'd0;
    mlo[sel] = 64'd0;
    @(posedge clk); #1;
    set_reset(sel, 1'b0);
    for (int c = 0; c < lat + 2; c++) begin
      @(posedge clk); #1;
      checks++;
      if (get_done(sel) !== 1'b0 || get_busy(sel) !== 1'b0) begin
        errors++; $display("FAIL abort_no_done sel=%0d cyc=%0d got done=%b busy=%b want 0 0", sel, c, get_done(sel), get_busy(sel));
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      mhi[s] = 64'd0;
      mlo[s] = 64'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      test_reset(s);
      test_mult(s);
      test_mac(s);
      test_div(s);
      test_div_edge(s);
      test_moves(s);
      test_ignore(s);
      test_back_to_back(s);
      test_abort(s);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit with HI/LO result registers, the sequential companion to the single-cycle ALU in the execute stage. It accepts one operation per start pulse and holds `busy` for a fixed, parameterised latency. HI/LO are committed on completion. The stall logic reads `busy` to hold later HI/LO-dependent instructions. Compared with the ALU it adds operand width as a parameter, signed and unsigned multiply and divide, multiply-accumulate and multiply-subtract, and a defined divide-by-zero result.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width; must be ≥ 2.
- `MUL_CYCLES`, 5, busy cycles for MULT/MULTU/MADD/MSUB; must be ≥ 1.
- `DIV_CYCLES`, 10, busy cycles for DIV/DIVU; must be ≥ 1.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled on a rising edge while `busy`=0.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB.
- `a`  in  WIDTH  operand A (dividend / multiplicand / MTHI-MTLO source).
- `b`  in  WIDTH  operand B (divisor / multiplier).
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse; HI/LO hold a freshly committed result.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE and RUN. A down-counter is sized for max(MUL_CYCLES, DIV_CYCLES).
- IDLE with `start`=1 and op ∈ {MULT, MULTU, DIV, DIVU, MADD, MSUB}:
  - Latch `a`, `b` and `op`.
  - Load the counter with the op's latency.
  - Go to RUN.
- IDLE with `start`=1 and op ∈ {MTHI, MTLO}:
  - Write `a` to HI or LO at that edge.
  - No busy, no `done`.
- RUN:
  - Decrement the counter each cycle.
  - On the edge where the counter is 1: commit the result, return to IDLE, set `done`=1 for the next cycle.
- `start` while `busy`=1: ignored entirely. Latched operands are unaffected. The stall logic must not issue it.
- `a`/`b` may change freely after the start edge; only the latched copies are used.
- Arithmetic:
  - MULT: {HI,LO} = signed a × signed b (2·WIDTH-bit product).
  - MULTU: {HI,LO} = unsigned product.
  - MADD: {HI,LO} = {HI,LO} + signed product, modulo 2^(2·WIDTH).
  - MSUB: {HI,LO} = {HI,LO} − signed product, modulo 2^(2·WIDTH).
  - MADD/MSUB use the HI/LO value present at commit time.
  - DIV: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (DIV or DIVU, b=0): LO = all ones, HI = a. Full latency and `done` are still produced.
- Signed overflow (DIV, a = most negative, b = −1): LO = a, HI = 0.
- Implementation may be iterative or may compute at commit. Only commit timing is architecturally visible.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- `reset` asserted mid-operation aborts the operation immediately. HI/LO clear; no `done` follows.
- Start accepted at edge E0 → `busy`=1 from E0 to edge E0+N (N = op latency), then 0.
- HI/LO change exactly at edge E0+N; `done`=1 for the single cycle after E0+N.
- Back-to-back: a new `start` may be sampled at edge E0+N+1 (the cycle where `done`=1).
- MTHI/MTLO: write visible the cycle after the start edge.
- HI/LO hold their value through the whole busy window.
- Reserved combinations: none; all 8 op codes are defined.

## Test plan
- Reset, then MULT a=0xFFFFFFFE (−2), b=3 → `busy` for 5 cycles; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA; `done` pulses once.
- MULTU a=0xFFFFFFFF, b=2 → `hi`=0x00000001, `lo`=0xFFFFFFFE; then MADD a=1, b=1 → `hi`=0x00000001, `lo`=0xFFFFFFFF; then MSUB a=2, b=1 → `lo`=0xFFFFFFFD.
- DIV a=−7, b=2 → 10 busy cycles; `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1). DIVU a=7, b=2 → `lo`=3, `hi`=1.
- Edge divides: DIVU a=5, b=0 → `lo`=0xFFFFFFFF, `hi`=5. DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- MTHI a=0x1234, then MTLO a=0x5678 in consecutive cycles → `hi`=0x1234, `lo`=0x5678, `busy` never set. A `start` (MTLO a=0xDEAD) issued mid-DIV → ignored; DIV result intact.
- Assert `reset` at cycle 3 of a MULT → `busy`, `hi`, `lo` = 0 immediately; no `done`. Repeat all scenarios with WIDTH=16, MUL_CYCLES=1, DIV_CYCLES=3.
